// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with a registered valid/ready handshake.
// Optional performance counters (stall_cnt, bp_cnt) are built when PIPE_PERF_CNT_EN is defined.
module pipe_skid_reg #(
  parameter int unsigned DATA_W   = 64,
  parameter bit          CLR_DATA = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bp_cnt
`endif
);

  // State encoding is {skid_v, main_v}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;
  logic              acc;
  logic              fire;

  if (DATA_W < 1 || CNT_W < 1) begin : g_bad_params
    $error("pipe_skid_reg: DATA_W and CNT_W must be at least 1");
  end

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_d;
  assign acc       = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  // Payload in the flush cycle is dropped; the skid entry always drains into main first.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= EMPTY;
      if (CLR_DATA) begin
        main_d <= '0;
        skid_d <= '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state  <= ONE;
            main_d <= in_data;
          end
        end
        ONE: begin
          if (acc && fire) begin
            main_d <= in_data;
          end else if (acc) begin
            state  <= TWO;
            skid_d <= in_data;
          end else if (fire) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (fire) begin
            state  <= ONE;
            main_d <= skid_d;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic stall_cond;
  logic bp_cond;

  assign stall_cond = out_valid & ~out_ready;
  assign bp_cond    = in_valid & ~in_ready;

  // Saturating counters; flush does not clear them, only rst does.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      bp_cnt    <= '0;
    end else begin
      if (stall_cond && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (bp_cond && (bp_cnt != {CNT_W{1'b1}})) begin
        bp_cnt <= bp_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
